// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between the fetch port and the load/store port.
// Data port has fixed priority; a starvation guard forces fetch through after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [12:0]      i_addr,
  output logic             i_ack,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [12:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_ack,
  output logic [31:0]      d_rdata,
  output logic             mem_we,
  output logic [12:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic             owner_d_q;
  logic             we_q;
  logic [12:0]      addr_q;
  logic [31:0]      din_q;
  logic [3:0]       starve_q;
  logic [31:0]      i_hold_q, d_hold_q;
  logic [CNT_W-1:0] i_cnt_q, d_cnt_q;
  logic             issue;
  logic             win_d;

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

  // Issue happens combinationally in IDLE; rst_n gating keeps mem_we/mem_addr quiet during reset
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    win_d    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = addr_q;
    mem_din  = din_q;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    i_rdata  = i_hold_q;
    d_rdata  = d_hold_q;
    case (state_q)
      IDLE: begin
        if (rst_n && (i_req || d_req)) begin
          issue   = 1'b1;
          win_d   = d_req && !(i_req && (starve_q == LIMIT));
          state_d = RESP;
          if (win_d) begin
            mem_addr = d_addr;
            mem_we   = d_we;
            mem_din  = d_wdata;
          end else begin
            mem_addr = i_addr;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_d_q) begin
          d_ack = 1'b1;
          if (!we_q) d_rdata = mem_dout;
        end else begin
          i_ack   = 1'b1;
          i_rdata = mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      starve_q  <= '0;
      i_hold_q  <= '0;
      d_hold_q  <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        owner_d_q <= win_d;
        we_q      <= win_d && d_we;
        addr_q    <= mem_addr;
        din_q     <= mem_din;
        // Count only data wins that made a waiting fetch wait longer
        if (win_d && i_req)
          starve_q <= (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
        else
          starve_q <= '0;
      end
      if (state_q == RESP) begin
        if (owner_d_q) begin
          d_cnt_q <= d_cnt_q + 1'b1;
          if (!we_q) d_hold_q <= mem_dout;
        end else begin
          i_cnt_q  <= i_cnt_q + 1'b1;
          i_hold_q <= mem_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level reference model, directed and random traffic.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [12:0]   i_addr, d_addr;
  logic [31:0]   d_wdata;
  logic          i_ack, d_ack, mem_we;
  logic [31:0]   i_rdata, d_rdata, mem_din, mem_dout;
  logic [12:0]   mem_addr;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [12:0] a);
    return (a == 13'd5) ? 32'hDEADBEEF : ({19'd0, a} * 32'h00010001) ^ 32'h5A5A0000;
  endfunction

  // Environment memory: synchronous read, one write or read per edge
  logic [31:0] mem [0:8191];
  bit          written [0:8191];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_din;
      written[mem_addr] <= 1'b1;
    end else begin
      mem_dout <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end
  end

  // Reference model state (transaction level)
  logic [31:0] ref_mem [int];
  bit          m_busy, m_own_d, m_we;
  logic [12:0] m_addr;
  int          starve, icnt, dcnt;
  logic [31:0] ihold, dhold;
  int          i_mode, d_mode;
  int          we_seen;
  bit          glog [$];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] ref_rd(input logic [12:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_we = 0; m_addr = '0;
    starve = 0; icnt = 0; dcnt = 0; ihold = '0; dhold = '0;
  endtask

  task automatic new_d();
    d_we    = ($urandom_range(0, 1) == 1);
    d_addr  = 13'($urandom);
    d_wdata = $urandom;
  endtask

  // One clock: check outputs mid-cycle, advance model across the edge, then update requesters
  task automatic tick();
    bit          eia, eda, iss, wd;
    logic [31:0] ei, ed;
    logic [12:0] ea;
    @(negedge clk);
    eia = m_busy && !m_own_d;
    eda = m_busy && m_own_d;
    ei  = eia ? ref_rd(m_addr) : ihold;
    ed  = (eda && !m_we) ? ref_rd(m_addr) : dhold;
    iss = !m_busy && (i_req || d_req);
    wd  = d_req && !(i_req && starve == LIMIT);
    ea  = iss ? (wd ? d_addr : i_addr) : m_addr;
    chk("i_ack", i_ack, eia);
    chk("d_ack", d_ack, eda);
    chk("i_rdata", i_rdata, ei);
    chk("d_rdata", d_rdata, ed);
    chk("mem_we", mem_we, iss && wd && d_we);
    chk("mem_addr", mem_addr, ea);
    if (iss && wd && d_we) chk("mem_din", mem_din, d_wdata);
    chk("i_cnt", i_grant_cnt, icnt);
    chk("d_cnt", d_grant_cnt, dcnt);
    if (mem_we) we_seen++;
    if (i_ack) glog.push_back(1'b0);
    if (d_ack) glog.push_back(1'b1);
    if (m_busy) begin
      if (eia) begin icnt = (icnt + 1) % (1 << CW); ihold = ei; end
      else begin dcnt = (dcnt + 1) % (1 << CW); dhold = ed; end
      m_busy = 0;
    end else if (iss) begin
      m_busy  = 1;
      m_own_d = wd;
      m_we    = wd && d_we;
      m_addr  = ea;
      if (m_we) ref_mem[int'(ea)] = d_wdata;
      starve  = (wd && i_req) ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
    end
    @(posedge clk);
    #1;
    if (eia) begin
      if (i_mode == 0) i_req = 0;
      else begin
        i_addr = 13'($urandom);
        if (i_mode == 2) i_req = ($urandom_range(0, 1) == 1);
      end
    end else if (i_mode == 2 && !i_req && $urandom_range(0, 2) == 0) begin
      i_req = 1; i_addr = 13'($urandom);
    end
    if (eda) begin
      if (d_mode == 0) d_req = 0;
      else begin
        new_d();
        if (d_mode == 2) d_req = ($urandom_range(0, 1) == 1);
      end
    end else if (d_mode == 2 && !d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1; new_d();
    end
  endtask

  task automatic drain();
    i_mode = 0; d_mode = 0;
    for (int k = 0; k < 20 && (i_req || d_req); k++) tick();
    chk("drain_done", {i_req, d_req}, 2'b00);
    tick();
  endtask

  initial begin
    rst_n = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    i_mode = 0; d_mode = 0; we_seen = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    chk("rst_mem", {mem_we, mem_addr, mem_din}, 0);
    chk("rst_cnts", {i_grant_cnt, d_grant_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Single fetch of word 5
    i_addr = 13'h005; i_req = 1;
    tick(); tick(); tick();
    chk("fetch_rdata_hold", i_rdata, 32'hDEADBEEF);
    chk("fetch_cnt", i_grant_cnt, 1);

    // Store then load of the top word
    we_seen = 0;
    d_req = 1; d_we = 1; d_addr = 13'h1FFF; d_wdata = 32'h12345678;
    tick(); tick();
    chk("store_rdata_unchanged", d_rdata, 0);
    d_req = 1; d_we = 0;
    tick(); tick(); tick();
    chk("load_rdata", d_rdata, 32'h12345678);
    chk("store_load_cnt", d_grant_cnt, 2);
    chk("store_we_edges", we_seen, 1);

    // Continuous contention: D,D,D,D,I repeating
    glog.delete();
    i_mode = 1; d_mode = 1;
    i_req = 1; i_addr = 13'($urandom); d_req = 1; new_d();
    for (int k = 0; k < 40; k++) tick();
    chk("contend_grants", glog.size(), 20);
    for (int k = 0; k < 20 && k < glog.size(); k++)
      chk($sformatf("contend_order_%0d", k), glog[k], (k % 5) != 4);
    drain();

    // Starvation counter cleared when a data grant happens without fetch waiting
    d_mode = 1; i_mode = 0;
    i_req = 1; i_addr = 13'h0042; d_req = 1; new_d();
    tick(); tick(); tick(); tick();
    i_req = 0;
    tick(); tick();
    glog.delete();
    i_req = 1; i_addr = 13'h0043;
    for (int k = 0; k < 10; k++) tick();
    chk("starve_grants", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      chk($sformatf("starve_order_%0d", k), glog[k], k != 4);
    drain();

    // Reset in the response cycle of a write
    d_req = 1; d_we = 1; d_addr = 13'h010; d_wdata = 32'hA5A5A5A5;
    tick();
    #2;
    rst_n = 0; i_req = 0; d_req = 0;
    #1;
    chk("rstmid_d_ack", d_ack, 0);
    chk("rstmid_i_ack", i_ack, 0);
    chk("rstmid_cnts", {i_grant_cnt, d_grant_cnt}, 0);
    chk("rstmid_mem", {mem_we, mem_addr, mem_din}, 0);
    chk("rstmid_rdata", {i_rdata, d_rdata}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    d_req = 1; d_we = 0; d_addr = 13'h010;
    tick(); tick(); tick();
    chk("rstmid_readback", d_rdata, 32'hA5A5A5A5);
    chk("rstmid_dcnt", d_grant_cnt, 1);

    // Counter wrap: 17 fetches on a 4-bit counter
    i_mode = 1; i_req = 1; i_addr = 13'($urandom);
    for (int k = 0; k < 33; k++) tick();
    i_mode = 0;
    tick();
    chk("wrap_icnt", i_grant_cnt, 1);
    tick();

    // Random mixed traffic
    i_mode = 2; d_mode = 2;
    for (int k = 0; k < 400; k++) tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
